vector_alu_issue: RTL and testbench

- Drives the scalar ALU interface from the opposite side: accepts one vector ALU request (op, THREADS operand pairs, active-thread mask) and time-multiplexes it onto a pool of LANES combinational scalar ALUs.
- Collects lane results and flags back into a full THREADS-wide response.
- Sits between decode/operand read and writeback in the SIMT pipeline.
- Lets a narrow ALU pool serve a wide warp.

---
 rtl/vector_alu_issue.sv | 154 +++++++++++++++
 tb/tb_vector_alu_issue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_issue.sv
// Issues one THREADS-wide ALU request onto a pool of LANES scalar ALUs, one lane group per cycle, and collects the results.
// Optional VALU_GROUP_SKIP_EN skips lane groups whose mask bits are all zero.
module vector_alu_issue #(
  parameter int THREADS = 4,
  parameter int LANES   = 2,
  parameter int WIDTH   = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [3:0]                 req_op,
  input  logic [THREADS*WIDTH-1:0]   req_porta,
  input  logic [THREADS*WIDTH-1:0]   req_portb,
  input  logic [THREADS-1:0]         req_mask,
  output logic [3:0]                 lane_op,
  output logic [LANES*WIDTH-1:0]     lane_porta,
  output logic [LANES*WIDTH-1:0]     lane_portb,
  input  logic [LANES*WIDTH-1:0]     lane_out,
  input  logic [LANES-1:0]           lane_nf,
  input  logic [LANES-1:0]           lane_zf,
  input  logic [LANES-1:0]           lane_of,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [THREADS*WIDTH-1:0]   rsp_out,
  output logic [THREADS-1:0]         rsp_nf,
  output logic [THREADS-1:0]         rsp_zf,
  output logic [THREADS-1:0]         rsp_of
);

  localparam int GROUPS = THREADS / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CW1    = CW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                     state, state_next;
  logic [CW-1:0]              cnt;
  logic [THREADS*WIDTH-1:0]   porta_q, portb_q;
  logic [THREADS-1:0]         mask_q;
  logic                       first_found, next_found;
  logic [CW-1:0]              first_idx, next_idx;
  logic [CW-1:0]              load_idx;
  logic [THREADS*WIDTH-1:0]   load_a_src, load_b_src;
  logic [LANES*WIDTH-1:0]     load_a, load_b;

`ifdef VALU_GROUP_SKIP_EN
  // Lowest group at or above start with any active thread; MSB flags whether one exists.
  function automatic logic [CW:0] find_group(input logic [THREADS-1:0] m, input logic [CW:0] start);
    logic [CW:0] r;
    r = '0;
    for (int g = GROUPS - 1; g >= 0; g--)
      if (CW1'(g) >= start && |m[g*LANES +: LANES])
        r = {1'b1, CW'(g)};
    return r;
  endfunction

  always_comb begin
    {first_found, first_idx} = find_group(req_mask, '0);
    {next_found, next_idx}   = find_group(mask_q, {1'b0, cnt} + CW1'(1));
  end
`else
  always_comb begin
    first_found = 1'b1;
    first_idx   = '0;
    next_found  = (cnt != CW'(GROUPS - 1));
    next_idx    = cnt + CW'(1);
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = first_found ? ISSUE : DONE;
      ISSUE:   if (!next_found) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  // The first group loads straight from the request; later groups come from the latched operands.
  always_comb begin
    load_idx   = (state == IDLE) ? first_idx : next_idx;
    load_a_src = (state == IDLE) ? req_porta : porta_q;
    load_b_src = (state == IDLE) ? req_portb : portb_q;
    load_a     = '0;
    load_b     = '0;
    for (int g = 0; g < GROUPS; g++)
      if (CW'(g) == load_idx) begin
        load_a = load_a_src[g*LANES*WIDTH +: LANES*WIDTH];
        load_b = load_b_src[g*LANES*WIDTH +: LANES*WIDTH];
      end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt        <= '0;
      porta_q    <= '0;
      portb_q    <= '0;
      mask_q     <= '0;
      lane_op    <= '0;
      lane_porta <= '0;
      lane_portb <= '0;
      rsp_out    <= '0;
      rsp_nf     <= '0;
      rsp_zf     <= '0;
      rsp_of     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          porta_q <= req_porta;
          portb_q <= req_portb;
          mask_q  <= req_mask;
          cnt     <= first_idx;
          rsp_out <= '0;
          rsp_nf  <= '0;
          rsp_zf  <= '0;
          rsp_of  <= '0;
          if (first_found) begin
            lane_op    <= req_op;
            lane_porta <= load_a;
            lane_portb <= load_b;
          end
        end
        ISSUE: begin
          for (int t = 0; t < THREADS; t++)
            if (CW'(t / LANES) == cnt && mask_q[t]) begin
              rsp_out[t*WIDTH +: WIDTH] <= lane_out[(t % LANES)*WIDTH +: WIDTH];
              rsp_nf[t]                 <= lane_nf[t % LANES];
              rsp_zf[t]                 <= lane_zf[t % LANES];
              rsp_of[t]                 <= lane_of[t % LANES];
            end
          if (next_found) begin
            cnt        <= next_idx;
            lane_porta <= load_a;
            lane_portb <= load_b;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_issue.sv
// Testbench for vector_alu_issue: bench-side scalar ALUs on the lane ports, a response model with queue and latency,
// and directed vectors with literal expectations. Honours VALU_GROUP_SKIP_EN for expected latencies.
module tb_vector_alu_issue;

  localparam int THREADS = 4;
  localparam int LANES   = 2;
  localparam int WIDTH   = 32;
  localparam int GROUPS  = THREADS / LANES;
  localparam int CMPW    = THREADS * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic                   CLK, nRST;
  logic                   req_valid, req_ready;
  logic [3:0]             req_op;
  logic [CMPW-1:0]        req_porta, req_portb;
  logic [THREADS-1:0]     req_mask;
  logic [3:0]             lane_op;
  logic [LANES*WIDTH-1:0] lane_porta, lane_portb, lane_out;
  logic [LANES-1:0]       lane_nf, lane_zf, lane_of;
  logic                   rsp_valid, rsp_ready;
  logic [CMPW-1:0]        rsp_out;
  logic [THREADS-1:0]     rsp_nf, rsp_zf, rsp_of;

  int compared   = 0;
  int mismatched = 0;

  vector_alu_issue #(.THREADS(THREADS), .LANES(LANES), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_porta(req_porta), .req_portb(req_portb), .req_mask(req_mask),
    .lane_op(lane_op), .lane_porta(lane_porta), .lane_portb(lane_portb),
    .lane_out(lane_out), .lane_nf(lane_nf), .lane_zf(lane_zf), .lane_of(lane_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_nf(rsp_nf), .rsp_zf(rsp_zf), .rsp_of(rsp_of)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             n;
    logic             z;
    logic             o;
  } alu_res_t;

  typedef struct {
    logic [CMPW-1:0]    out;
    logic [THREADS-1:0] nf, zf, of;
    int                 lat;
  } exp_t;

  function automatic alu_res_t alu(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    alu_res_t res;
    res = '0;
    case (op)
      OP_ADD: begin res.r = a + b; res.o = (a[WIDTH-1] == b[WIDTH-1]) && (res.r[WIDTH-1] != a[WIDTH-1]); end
      OP_SUB: begin res.r = a - b; res.o = (a[WIDTH-1] != b[WIDTH-1]) && (res.r[WIDTH-1] != a[WIDTH-1]); end
      OP_AND: res.r = a & b;
      OP_OR:  res.r = a | b;
      OP_XOR: res.r = a ^ b;
      default: res.r = '0;
    endcase
    res.n = res.r[WIDTH-1];
    res.z = (res.r == '0);
    return res;
  endfunction

  // Scalar ALU pool seen from the lane side
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    alu_res_t lr;
    assign lr = alu(lane_op, lane_porta[k*WIDTH +: WIDTH], lane_portb[k*WIDTH +: WIDTH]);
    assign lane_out[k*WIDTH +: WIDTH] = lr.r;
    assign lane_nf[k] = lr.n;
    assign lane_zf[k] = lr.z;
    assign lane_of[k] = lr.o;
  end

  function automatic exp_t model(input logic [3:0] op, input logic [CMPW-1:0] a, input logic [CMPW-1:0] b,
                                 input logic [THREADS-1:0] m);
    exp_t e;
    alu_res_t r;
    e.out = '0; e.nf = '0; e.zf = '0; e.of = '0; e.lat = 0;
    for (int t = 0; t < THREADS; t++)
      if (m[t]) begin
        r = alu(op, a[t*WIDTH +: WIDTH], b[t*WIDTH +: WIDTH]);
        e.out[t*WIDTH +: WIDTH] = r.r;
        e.nf[t] = r.n; e.zf[t] = r.z; e.of[t] = r.o;
      end
    for (int g = 0; g < GROUPS; g++) begin
`ifdef VALU_GROUP_SKIP_EN
      if (m[g*LANES +: LANES] != '0) e.lat++;
`else
      e.lat++;
`endif
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [CMPW-1:0] act, input logic [CMPW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Response model: one outstanding request, edges counted since its accept
  exp_t exp_q[$];
  int   age;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exp_q.delete();
      age <= 0;
    end else begin
      if (exp_q.size() > 0 && age >= exp_q[0].lat && rsp_ready)
        exp_q.pop_front();
      if (exp_q.size() == 0 && req_valid) begin
        exp_q.push_back(model(req_op, req_porta, req_portb, req_mask));
        age <= 0;
      end else begin
        age <= age + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST) begin
      logic exp_valid;
      exp_valid = 1'b0;
      if (exp_q.size() > 0) exp_valid = (age >= exp_q[0].lat);
      checkOutput("req_ready", CMPW'(req_ready), CMPW'(exp_q.size() == 0));
      checkOutput("rsp_valid", CMPW'(rsp_valid), CMPW'(exp_valid));
      if (exp_valid) begin
        checkOutput("rsp_out", rsp_out, exp_q[0].out);
        checkOutput("rsp_nf", CMPW'(rsp_nf), CMPW'(exp_q[0].nf));
        checkOutput("rsp_zf", CMPW'(rsp_zf), CMPW'(exp_q[0].zf));
        checkOutput("rsp_of", CMPW'(rsp_of), CMPW'(exp_q[0].of));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [CMPW-1:0] a, input logic [CMPW-1:0] b,
                               input logic [THREADS-1:0] m);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL req_ready_wait: got 0, expected 1 within 50 cycles");
    end
    req_op    = op;
    req_porta = a;
    req_portb = b;
    req_mask  = m;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  // Edges after the accept edge until rsp_valid is seen; -1 if it never arrives
  task automatic waitResponse(output int edges);
    edges = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        edges = n;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic releaseResponse();
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    nRST = 1'b0; req_valid = 1'b0; req_op = '0; req_porta = '0; req_portb = '0; req_mask = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_req_ready", CMPW'(req_ready), CMPW'(1));
    checkOutput("rst_rsp_valid", CMPW'(rsp_valid), CMPW'(0));
    checkOutput("rst_rsp_out", rsp_out, '0);
    checkOutput("rst_flags", CMPW'({rsp_nf, rsp_zf, rsp_of}), '0);
    checkOutput("rst_lane_op", CMPW'(lane_op), '0);
    checkOutput("rst_lane_ports", CMPW'({lane_porta, lane_portb}), '0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] add, full mask");
    applyStimulus(OP_ADD, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, 4'b1111);
    waitResponse(lat);
    checkOutput("add_latency", CMPW'(lat), CMPW'(2));
    checkOutput("add_out", rsp_out, {32'd44, 32'd33, 32'd22, 32'd11});
    checkOutput("add_flags", CMPW'({rsp_nf, rsp_zf, rsp_of}), '0);
    checkOutput("add_lane_hold_a", CMPW'(lane_porta), CMPW'({32'd4, 32'd3}));
    checkOutput("add_lane_op", CMPW'(lane_op), CMPW'(OP_ADD));
    releaseResponse();
    checkOutput("add_release", CMPW'(rsp_valid), CMPW'(0));

    $display("[TB] sub, mask 0101");
    applyStimulus(OP_SUB, {4{32'd5}}, {4{32'd5}}, 4'b0101);
    waitResponse(lat);
    checkOutput("sub_latency", CMPW'(lat), CMPW'(2));
    checkOutput("sub_out", rsp_out, '0);
    checkOutput("sub_zf", CMPW'(rsp_zf), CMPW'(4'b0101));
    checkOutput("sub_nf_of", CMPW'({rsp_nf, rsp_of}), '0);
    releaseResponse();

    $display("[TB] add overflow, thread 3 only");
    applyStimulus(OP_ADD, {32'h7FFFFFFF, 32'd1, 32'd1, 32'd1}, {32'd1, 32'd2, 32'd2, 32'd2}, 4'b1000);
    waitResponse(lat);
`ifdef VALU_GROUP_SKIP_EN
    checkOutput("ovf_latency", CMPW'(lat), CMPW'(1));
`else
    checkOutput("ovf_latency", CMPW'(lat), CMPW'(2));
`endif
    checkOutput("ovf_out", rsp_out, {32'h80000000, 96'h0});
    checkOutput("ovf_of", CMPW'(rsp_of), CMPW'(4'b1000));
    checkOutput("ovf_nf", CMPW'(rsp_nf), CMPW'(4'b1000));
    checkOutput("ovf_zf", CMPW'(rsp_zf), CMPW'(4'b0000));
    releaseResponse();

    $display("[TB] xor with backpressure");
    rsp_ready = 1'b0;
    applyStimulus(OP_XOR, {32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h12345678},
                  {32'hF0F0F0F0, 32'h00000000, 32'hFFFF0000, 32'h00000078}, 4'b1111);
    waitResponse(lat);
    checkOutput("bp_latency", CMPW'(lat), CMPW'(2));
    req_op = OP_SUB; req_porta = {4{32'hDEADBEEF}}; req_portb = '0; req_mask = 4'b1111; req_valid = 1'b1;
    repeat (5) begin
      @(posedge CLK); @(negedge CLK);
      checkOutput("bp_rsp_valid", CMPW'(rsp_valid), CMPW'(1));
      checkOutput("bp_req_ready", CMPW'(req_ready), CMPW'(0));
      checkOutput("bp_out", rsp_out, {32'h0, 32'h0F0F0F0F, 32'h0000FFFF, 32'h12345600});
      checkOutput("bp_zf", CMPW'(rsp_zf), CMPW'(4'b1000));
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    checkOutput("bp_release", CMPW'(rsp_valid), CMPW'(0));

    $display("[TB] reset during issue");
    applyStimulus(OP_ADD, {32'd400, 32'd300, 32'd200, 32'd100}, {4{32'd7}}, 4'b1111);
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", CMPW'(rsp_valid), CMPW'(0));
    checkOutput("abort_req_ready", CMPW'(req_ready), CMPW'(1));
    checkOutput("abort_rsp_out", rsp_out, '0);
    checkOutput("abort_lane_a", CMPW'(lane_porta), '0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(OP_SUB, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0110);
    waitResponse(lat);
    checkOutput("post_rst_latency", CMPW'(lat), CMPW'(2));
    checkOutput("post_rst_out", rsp_out, {32'd0, 32'd27, 32'd18, 32'd0});
    checkOutput("post_rst_flags", CMPW'({rsp_nf, rsp_zf, rsp_of}), '0);
    releaseResponse();

    $display("[TB] or, upper group only");
    applyStimulus(OP_OR, {32'h000000F0, 32'h0000000F, 32'h1, 32'h2}, {32'h0000000F, 32'h00000F00, 32'h4, 32'h8}, 4'b1100);
    waitResponse(lat);
`ifdef VALU_GROUP_SKIP_EN
    checkOutput("upper_latency", CMPW'(lat), CMPW'(1));
`else
    checkOutput("upper_latency", CMPW'(lat), CMPW'(2));
`endif
    checkOutput("upper_out", rsp_out, {32'h000000FF, 32'h00000F0F, 64'h0});
    releaseResponse();

    $display("[TB] empty mask");
    applyStimulus(OP_ADD, {4{32'h11111111}}, {4{32'h22222222}}, 4'b0000);
    waitResponse(lat);
`ifdef VALU_GROUP_SKIP_EN
    checkOutput("empty_latency", CMPW'(lat), CMPW'(0));
`else
    checkOutput("empty_latency", CMPW'(lat), CMPW'(2));
`endif
    checkOutput("empty_out", rsp_out, '0);
    checkOutput("empty_flags", CMPW'({rsp_nf, rsp_zf, rsp_of}), '0);
    releaseResponse();

    $display("[TB] model-checked vectors");
    applyStimulus(OP_AND, {32'hFFFF0000, 32'h12345678, 32'h0F0F0F0F, 32'h80000001},
                  {32'h00FF00FF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h80000000}, 4'b1011);
    waitResponse(lat);
    releaseResponse();
    applyStimulus(OP_SUB, {32'h80000000, 32'd0, 32'd3, 32'd9}, {32'd1, 32'd1, 32'd3, 32'd2}, 4'b1111);
    waitResponse(lat);
    releaseResponse();
    applyStimulus(OP_ADD, {32'h1, 32'hFFFFFFFF, 32'h40000000, 32'h5}, {32'h2, 32'h1, 32'h40000000, 32'h6}, 4'b0011);
    waitResponse(lat);
    releaseResponse();

    repeat (3) @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
